// File: rtl/multicycle_ctrl.sv
// Purpose : control FSM sequencing the multicycle RV32I-subset datapath (fetch/decode/execute/writeback).
// Latency : one state per clock; lw 6 cycles, sw/R/I/jal 5, beq/bne 4 (IDLE cycle included in free-run).
// Backpressure: none; execution is gated only by run (free-run) or a rising edge on step (single-step).
//
// Ports:
//   clk_2, reset_n            clock, asynchronous active-low reset
//   run, step                 free-run level / raw single-step switch level
//   opcode, funct3, zero      instruction fields from IR, ALU zero flag
//   pc_write ... alu_op       datapath enables and mux selects
//   state, halted             current state encoding and HALT flag for the debug display
//   instr_count               retired-instruction counter, wraps at 2^NBITS
module multicycle_ctrl #(
    parameter int NBITS = 8
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic             run,
    input  logic             step,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             halted,
    output logic [NBITS-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t           r_state;
    state_t           w_next;
    logic             r_step_q;
    logic [NBITS-1:0] r_instr_count;
    logic             w_step_rise;
    logic             w_pc_update;
    logic             w_branch;
    logic             w_retire;

    assign w_step_rise = step & ~r_step_q;
    // Retirement is any return to IDLE; HALT never returns, so it is never counted.
    assign w_retire    = (r_state != S_IDLE) && (w_next == S_IDLE);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_step_q      <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state  <= w_next;
            r_step_q <= step;
            if (w_retire) begin
                r_instr_count <= r_instr_count + {{(NBITS-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        halted      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A step edge seen outside IDLE is simply lost: step_q tracks every cycle.
                if (run || w_step_rise) w_next = S_FETCH;
            end
            S_FETCH: begin
                ir_write    = 1'b1;
                w_pc_update = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECR;
                    OP_ITYPE:     w_next = S_EXECI;
                    OP_BRANCH:    w_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_HALT;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                // IR still holds the instruction, so the opcode picks load vs store here.
                w_next    = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_next     = S_IDLE;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                w_next    = S_IDLE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_next    = S_IDLE;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                w_branch  = 1'b1;
                w_next    = S_IDLE;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_next = S_HALT;
        endcase
    end

    // The only Mealy term: branch resolution uses the live zero flag (beq when funct3[0]=0, bne when 1).
    assign pc_write    = w_pc_update | (w_branch & (zero ^ funct3[0]));
    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : self-checking bench for multicycle_ctrl against a per-instruction state-sequence model.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_multicycle_ctrl;

    localparam int NBITS = 8;

    logic             clk_2 = 1'b0;
    logic             reset_n = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic [6:0]       opcode = 7'd0;
    logic [2:0]       funct3 = 3'd0;
    logic             zero = 1'b0;
    logic             pc_write, ir_write, adr_src, mem_write, reg_write;
    logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
    logic [3:0]       state;
    logic             halted;
    logic [NBITS-1:0] instr_count;

    multicycle_ctrl #(.NBITS(NBITS)) dut (
        .clk_2(clk_2), .reset_n(reset_n), .run(run), .step(step),
        .opcode(opcode), .funct3(funct3), .zero(zero),
        .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk_2 = ~clk_2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the instruction is a list of states to walk through.
    int         m_state = 0;
    int         m_q[$];
    logic [7:0] m_count = 8'd0;
    logic       m_step_q = 1'b0;

    task automatic load_seq();
        case (opcode)
            7'b0000011: m_q = {1, 2, 3, 4, 5, 0};
            7'b0100011: m_q = {1, 2, 3, 6, 0};
            7'b0110011: m_q = {1, 2, 7, 9, 0};
            7'b0010011: m_q = {1, 2, 8, 9, 0};
            7'b1101111: m_q = {1, 2, 11, 9, 0};
            7'b1100011: begin
                if (funct3 == 3'd0 || funct3 == 3'd1) m_q = {1, 2, 10, 0};
                else                                  m_q = {1, 2, 15};
            end
            default:    m_q = {1, 2, 15};
        endcase
    endtask

    // {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, a, b, op, halted}
    function automatic logic [13:0] exp_outs(int st, logic [2:0] f3, logic z);
        logic taken;
        taken = z ^ f3[0];
        case (st)
            1:       return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
            2:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
            3:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
            4:       return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            5:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
            6:       return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            7:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
            8:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
            9:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            10:      return {taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
            11:      return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
            15:      return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
            default: return 14'd0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        logic [13:0] got, exp;
        got = {pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, halted};
        exp = exp_outs(m_state, funct3, zero);
        n_checks++;
        assert (state === 4'(m_state)) else begin
            n_errors++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, m_state);
        end
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s outputs (st %0d): got %b expected %b", tag, m_state, got, exp);
        end
        n_checks++;
        assert (instr_count === m_count) else begin
            n_errors++;
            $error("FAIL %s instr_count: got %0d expected %0d", tag, instr_count, m_count);
        end
    endtask

    // One clock: predict, clock, check at the following falling edge.
    task automatic tick(input string tag);
        int nxt;
        if (m_state == 15)              nxt = 15;
        else if (m_q.size() > 0)        nxt = m_q.pop_front();
        else if (run || (step && !m_step_q)) begin
            load_seq();
            nxt = m_q.pop_front();
        end else                        nxt = 0;
        if (nxt == 0 && m_state != 0) m_count = m_count + 8'd1;
        m_step_q = step;
        @(posedge clk_2);
        m_state = nxt;
        @(negedge clk_2);
        check_all(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Called at a falling edge; reset is asserted mid-cycle and must act immediately.
    task automatic do_reset(input string tag);
        #1 reset_n = 1'b0;
        #1;
        m_state  = 0;
        m_q.delete();
        m_count  = 8'd0;
        m_step_q = 1'b0;
        check_all(tag);
        @(posedge clk_2);
        @(negedge clk_2);
        check_all(tag);
        reset_n = 1'b1;
    endtask

    task automatic set_op(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
    endtask

    initial begin
        logic [6:0] ops[7];
        int         guard;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0000000};

        // Reset held, then lw in free-run.
        @(negedge clk_2);
        check_all("reset_held");
        set_op(7'b0000011, 3'd2);
        run = 1'b1;
        do_reset("reset");
        ticks(14, "lw_run");

        // Branches: beq taken, beq not taken, bne taken.
        run = 1'b0;
        do_reset("br_reset");
        set_op(7'b1100011, 3'b000); zero = 1'b1; run = 1'b1;
        ticks(4, "beq_taken");
        zero = 1'b0;
        ticks(4, "beq_not_taken");
        set_op(7'b1100011, 3'b001);
        ticks(4, "bne_taken");
        zero = 1'b1;
        ticks(4, "bne_not_taken");

        // Single-step: a held step executes one instruction only.
        run = 1'b0;
        do_reset("step_reset");
        set_op(7'b0110011, 3'd0);
        step = 1'b1;
        ticks(20, "step_held");
        step = 1'b0;
        ticks(3, "step_low");
        step = 1'b1;
        ticks(10, "step_again");
        step = 1'b0;

        // Illegal opcode: HALT is sticky and ignores run/step.
        do_reset("halt_reset");
        set_op(7'b0000000, 3'd0);
        run = 1'b1;
        ticks(3, "halt_enter");
        for (int i = 0; i < 50; i++) begin
            run  = 1'($urandom);
            step = 1'($urandom);
            tick("halt_hold");
        end

        // Reset inside MEMWRITE of the second store.
        run = 1'b0; step = 1'b0;
        do_reset("sw_reset");
        set_op(7'b0100011, 3'd2);
        run = 1'b1;
        ticks(5, "sw_first");
        guard = 0;
        while (m_state != 6 && guard < 20) begin
            tick("sw_to_memwrite");
            guard++;
        end
        n_checks++;
        assert (guard < 20) else begin
            n_errors++;
            $error("FAIL sw_timeout: got %0d cycles expected < 20", guard);
        end
        do_reset("sw_midreset");
        run = 1'b0;
        ticks(3, "sw_after_reset");

        // Counter wrap: 256 I-type instructions in free-run.
        set_op(7'b0010011, 3'd0);
        run = 1'b1;
        ticks(256 * 5, "wrap");
        n_checks++;
        assert (instr_count === 8'd0) else begin
            n_errors++;
            $error("FAIL wrap_count: got %0d expected 0", instr_count);
        end
        ticks(10, "wrap_after");

        // Randomized mixed traffic.
        for (int i = 0; i < 3000; i++) begin
            if (m_state == 0 && m_q.size() == 0) begin
                opcode = ops[$urandom_range(0, 6)];
                funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            end
            run  = ($urandom_range(0, 3) != 0);
            step = 1'($urandom);
            zero = 1'($urandom);
            tick("random");
            if (m_state == 15 && $urandom_range(0, 7) == 0) do_reset("random_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM that sequences the multicycle RV32I-subset datapath driven from the board top. It decodes the fetched opcode and issues per-cycle datapath enables and mux selects: PC/IR write, memory write, register write and ALU source/op selects. It supports free-run and single-step execution from a board switch. It exposes its state and a retired-instruction count for the LCD/LED debug display.

Parameters:
NBITS, 8, width of the retired-instruction counter (matches display byte width)

Ports:
clk_2  in  1  system clock
reset_n  in  1  asynchronous reset, active low
run  in  1  1 = free-run; 0 = single-step
step  in  1  raw step switch level; the block edge-detects it internally
opcode  in  7  instr[6:0] from IR
funct3  in  3  instr[14:12] from IR
zero  in  1  ALU zero flag
pc_write  out  1  PC register enable
ir_write  out  1  IR/oldPC enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  data memory write enable
reg_write  out  1  register file write enable
result_src  out  2  00 ALUOut, 01 ReadData, 10 ALUResult
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
state  out  4  current state encoding, for display
halted  out  1  1 in HALT
instr_count  out  NBITS  retired instructions, wraps

Behaviour:
- Reset: asynchronous on reset_n=0. State = IDLE, step_q = 0, instr_count = 0. All outputs 0.
- Outputs are Moore decode of the registered state. Only exception: pc_write = pc_update | (branch & taken).
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECR 7, EXECI 8, ALUWB 9, BRANCH 10, JAL 11, HALT 15.
- Step edge: step_rise = step & ~step_q, where step_q is registered every cycle.
- IDLE: all outputs 0.
  - Go to FETCH if run=1 or step_rise=1; otherwise stay.
  - A step_rise in any other state is dropped, not queued.
- FETCH: ir_write=1, pc_update=1, adr_src=0, a=00, b=10, op=00, result_src=10. Always go to DECODE.
- DECODE: a=01, b=01, op=00. Next state by opcode:
  - 0000011 -> MEMADR (lw)
  - 0100011 -> MEMADR (sw)
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH, if funct3 is 000 or 001; any other funct3 -> HALT
  - 1101111 -> JAL
  - anything else -> HALT
- MEMADR: a=10, b=01, op=00. Go to MEMREAD for lw, MEMWRITE for sw; the opcode is held stable by IR.
- MEMREAD: adr_src=1, result_src=00. Go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Go to IDLE.
- MEMWRITE: adr_src=1, mem_write=1, result_src=00. Go to IDLE.
- EXECR: a=10, b=00, op=10. Go to ALUWB.
- EXECI: a=10, b=01, op=10. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to IDLE.
- BRANCH: a=10, b=00, op=01, result_src=00, branch=1.
  - taken = zero ^ funct3[0] (beq/bne).
  - Go to IDLE.
- JAL: a=01, b=10, op=00, result_src=00, pc_update=1. Go to ALUWB.
- HALT: all enables 0, halted=1. Exits only by reset.
- Unlisted outputs are 0 in every state.
- instr_count increments by 1 (mod 2^NBITS) on every transition into IDLE from a non-IDLE state. HALT entry does not count.
- Cycles per instruction, including the IDLE cycle in run mode:
  - lw 6
  - sw, R-type, I-type, jal 5
  - beq/bne 4
- Reset asserted mid-instruction: immediate return to IDLE with outputs 0. No partial write is completed afterwards.

Test Plan:
- Reset held, then released with run=1 and opcode=0000011 held -> state sequence 0,1,2,3,4,5,0,1...; reg_write=1 only in state 5 with result_src=01; instr_count=1 after first return to IDLE.
- run=1, opcode=1100011, funct3=000, zero=1 -> pc_write=1 in BRANCH. Same with zero=0 -> pc_write=0. funct3=001, zero=0 -> pc_write=1.
- run=0, opcode=0110011, step held high 20 cycles -> exactly one instruction executes (states 1,2,7,9,0), instr_count=1. Toggle step low then high -> a second instruction executes.
- run=1, opcode=0000000 -> state 1,2,15; halted=1 persists 50 cycles; instr_count unchanged; outputs 0; step/run changes ignored.
- reset_n pulsed low during MEMWRITE (state 6) -> mem_write drops in the same cycle, state=0, instr_count=0.
- NBITS=8, run=1, opcode=0010011 for 256 instructions -> instr_count wraps 255 -> 0.
